// File: rtl/axi_bram_read_responder.sv
// AXI4 read-only slave returning fixed-length INCR bursts from an internal BRAM.
// The BRAM has one cycle of read latency and feeds a 2-entry show-ahead FIFO, so R never stalls AR logic.
module axi_bram_read_responder #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int MEM_DEPTH      = 1024,
  parameter int BURST_LEN      = 4,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  localparam int IDX_W = $clog2(MEM_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic                      s_axi_rvalid,
  output logic                      s_axi_rlast,
  input  logic                      s_axi_rready,
  input  logic                      wr_en,
  input  logic [IDX_W-1:0]          wr_idx,
  input  logic [AXI_DATA_WIDTH-1:0] wr_data,
  output logic                      err_oob
);

  localparam int DATA_BYTES = AXI_DATA_WIDTH / 8;
  localparam int OFF_W      = $clog2(DATA_BYTES);
  localparam int CNT_W      = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] BEATS     = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  state_t state;
  state_t state_next;

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [AXI_DATA_WIDTH-1:0] rd_data;
  logic                      rd_pending;
  logic [IDX_W-1:0]          rd_idx;
  logic [CNT_W-1:0]          beats_issued;
  logic [CNT_W-1:0]          beats_popped;

  logic [AXI_DATA_WIDTH-1:0] fifo_q0;
  logic [AXI_DATA_WIDTH-1:0] fifo_q1;
  logic [1:0]                fifo_count;

  logic ar_fire;
  logic r_fire;
  logic last_fire;
  logic issue;
  logic [2:0] occupancy;
  logic [2:0] capacity;

  // Top bit of the offset is the borrow, i.e. araddr below BASE_ADDR.
  logic [AXI_ADDR_WIDTH:0] offset;
  logic [IDX_W-1:0]        start_idx;
  logic                    start_oob;
  logic                    unused_low_bits;

  assign offset          = {1'b0, s_axi_araddr} - {1'b0, BASE_ADDR};
  assign start_idx       = offset[OFF_W +: IDX_W];
  assign start_oob       = offset[AXI_ADDR_WIDTH] | (|offset[AXI_ADDR_WIDTH-1:OFF_W+IDX_W]);
  assign unused_low_bits = ^offset[OFF_W-1:0];

  assign ar_fire   = s_axi_arvalid && s_axi_arready;
  assign r_fire    = s_axi_rvalid && s_axi_rready;
  assign last_fire = r_fire && (beats_popped == LAST_BEAT);

  // Reads are only issued when the FIFO is guaranteed room once they land.
  assign occupancy = {1'b0, fifo_count} + {2'b00, rd_pending};
  assign capacity  = 3'd2 + {2'b00, r_fire};
  assign issue     = (state == S_BURST) && (beats_issued < BEATS) && (occupancy < capacity);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (ar_fire) state_next = S_BURST;
      S_BURST: if (last_fire) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = 1'b0;
    if ((state == S_IDLE) && !rst) s_axi_arready = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beats_issued <= '0;
      beats_popped <= '0;
      rd_idx       <= '0;
      rd_pending   <= 1'b0;
      err_oob      <= 1'b0;
    end else begin
      if (ar_fire) begin
        beats_issued <= '0;
        beats_popped <= '0;
        rd_idx       <= start_idx;
        if (start_oob) err_oob <= 1'b1;
      end else begin
        if (issue) begin
          beats_issued <= beats_issued + CNT_W'(1);
          rd_idx       <= rd_idx + IDX_W'(1);
        end
        if (r_fire) beats_popped <= beats_popped + CNT_W'(1);
      end
      rd_pending <= issue;
    end
  end

  // Contents survive reset; a same-cycle write and read returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    if (issue) rd_data <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q0    <= '0;
      fifo_q1    <= '0;
      fifo_count <= 2'd0;
    end else begin
      case ({rd_pending, r_fire})
        2'b10: begin
          if (fifo_count == 2'd0) fifo_q0 <= rd_data;
          else fifo_q1 <= rd_data;
          fifo_count <= fifo_count + 2'd1;
        end
        2'b01: begin
          fifo_q0    <= fifo_q1;
          fifo_count <= fifo_count - 2'd1;
        end
        2'b11: begin
          if (fifo_count == 2'd1) begin
            fifo_q0 <= rd_data;
          end else begin
            fifo_q0 <= fifo_q1;
            fifo_q1 <= rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_axi_rvalid = (fifo_count != 2'd0);
  assign s_axi_rdata  = fifo_q0;
  assign s_axi_rlast  = s_axi_rvalid && (beats_popped == LAST_BEAT);

endmodule

// File: tb/tb_axi_bram_read_responder.sv
// Bench for axi_bram_read_responder: directed bursts against a queue-based memory model,
// plus literal cycle-exact expectations for the basic burst timing.
module tb_axi_bram_read_responder;

  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int DEPTH = 1024;
  localparam int BL    = 4;
  localparam int OFFB  = $clog2(DW / 8);
  localparam logic [AW-1:0] BASE = '0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          rlast;
  logic          rready;
  logic          wr_en;
  logic [9:0]    wr_idx;
  logic [DW-1:0] wr_data;
  logic          err_oob;

  always #5 clk = ~clk;

  axi_bram_read_responder #(
    .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW),
    .MEM_DEPTH(DEPTH),
    .BURST_LEN(BL),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axi_araddr(araddr),
    .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rdata(rdata),
    .s_axi_rvalid(rvalid),
    .s_axi_rlast(rlast),
    .s_axi_rready(rready),
    .wr_en(wr_en),
    .wr_idx(wr_idx),
    .wr_data(wr_data),
    .err_oob(err_oob)
  );

  int check_cnt = 0;
  int fail_cnt  = 0;
  int hs_cnt    = 0;
  int last_cnt  = 0;

  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_q[$];
  logic          exp_last_q[$];
  logic          m_oob = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] expected);
    check_cnt++;
    if (actual !== expected) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [DW-1:0] preload_val(input int k);
    if (k < 16) return 64'(k * 17);
    return 64'hC0DE_0000_0000_0000 | 64'(k);
  endfunction

  // Model of one accepted AR: the whole burst is expanded into expected beats.
  task automatic model_ar(input logic [AW-1:0] addr);
    longint off;
    longint word;
    off  = longint'(addr) - longint'(BASE);
    word = off >>> OFFB;
    if (off < 0 || word >= DEPTH) m_oob = 1'b1;
    for (int n = 0; n < BL; n++) begin
      exp_q.push_back(model_mem[int'((word + n) & (DEPTH - 1))]);
      exp_last_q.push_back(n == BL - 1);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en) model_mem[wr_idx] = wr_data;
    if (rst) begin
      exp_q.delete();
      exp_last_q.delete();
      m_oob      = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("err_oob", 64'(err_oob), 64'(m_oob));
      if (arready) chk("ar_while_busy", 64'(exp_q.size()), 64'd0);
      if (prev_stall) begin
        chk("stall_rvalid", 64'(rvalid), 64'd1);
        chk("stall_rdata", rdata, prev_data);
        chk("stall_rlast", 64'(rlast), 64'(prev_last));
      end
      chk("beat_unexpected", 64'(rvalid && exp_q.size() == 0), 64'd0);
      if (rvalid && exp_q.size() != 0) begin
        chk("rdata", rdata, exp_q[0]);
        chk("rlast", 64'(rlast), 64'(exp_last_q[0]));
        if (rready) begin
          void'(exp_q.pop_front());
          void'(exp_last_q.pop_front());
          hs_cnt++;
          if (rlast) last_cnt++;
        end
      end
      prev_stall = rvalid && !rready;
      prev_data  = rdata;
      prev_last  = rlast;
      if (arvalid && arready) model_ar(araddr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic do_ar(input logic [AW-1:0] addr);
    logic done;
    done    = 1'b0;
    araddr  = addr;
    arvalid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      sample();
      if (arready) done = 1'b1;
    end
    chk("ar_accept_timeout", 64'(done), 64'd1);
    tick();
    arvalid = 1'b0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      sample();
      if (exp_q.size() == 0 && arready && !rvalid) done = 1'b1;
    end
    chk("idle_timeout", 64'(done), 64'd1);
    tick();
  endtask

  task automatic first_beat(input string name, input logic [DW-1:0] expected);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      sample();
      if (rvalid) begin
        seen = 1'b1;
        chk(name, rdata, expected);
      end
    end
    chk("first_beat_timeout", 64'(seen), 64'd1);
  endtask

  initial begin
    int h0;
    int l0;
    int cnt;
    logic done;
    logic [5:0] pat;
    araddr  = '0;
    arvalid = 1'b0;
    rready  = 1'b1;
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    pat     = 6'b101001;

    repeat (3) @(posedge clk);
    sample();
    chk("reset_arready", 64'(arready), 64'd0);
    chk("reset_rvalid", 64'(rvalid), 64'd0);
    chk("reset_rlast", 64'(rlast), 64'd0);
    tick();
    rst = 1'b0;
    sample();
    chk("post_reset_arready", 64'(arready), 64'd1);
    chk("post_reset_rdata", rdata, 64'd0);
    chk("post_reset_err_oob", 64'(err_oob), 64'd0);
    chk("post_reset_rvalid", 64'(rvalid), 64'd0);

    for (int k = 0; k < DEPTH; k++) begin
      tick();
      wr_en   = 1'b1;
      wr_idx  = 10'(k);
      wr_data = preload_val(k);
    end
    tick();
    wr_en = 1'b0;

    // Test 1: cycle-exact burst from word 8
    h0      = hs_cnt;
    araddr  = 32'h40;
    arvalid = 1'b1;
    sample();
    chk("t1_arready_T", 64'(arready), 64'd1);
    tick();
    arvalid = 1'b0;
    sample();
    chk("t1_arready_T1", 64'(arready), 64'd0);
    sample();
    chk("t1_rvalid_T2", 64'(rvalid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("t1_rvalid", 64'(rvalid), 64'd1);
      chk("t1_rdata", rdata, 64'((8 + i) * 17));
      chk("t1_rlast", 64'(rlast), 64'(i == 3));
    end
    sample();
    chk("t1_arready_T7", 64'(arready), 64'd1);
    chk("t1_rvalid_T7", 64'(rvalid), 64'd0);
    chk("t1_beats", 64'(hs_cnt - h0), 64'd4);
    tick();

    // Test 2: wrap at top of memory
    h0 = hs_cnt;
    do_ar(32'h1FF8);
    first_beat("t2_first_word1023", 64'hC0DE_0000_0000_03FF);
    wait_idle();
    chk("t2_err_oob", 64'(err_oob), 64'd0);
    chk("t2_beats", 64'(hs_cnt - h0), 64'd4);

    // Test 3: rready toggling
    h0 = hs_cnt;
    l0 = last_cnt;
    do_ar(32'h40);
    for (int i = 0; i < 60; i++) begin
      rready = pat[i % 6];
      tick();
    end
    rready = 1'b1;
    wait_idle();
    chk("t3_beats", 64'(hs_cnt - h0), 64'd4);
    chk("t3_rlast_count", 64'(last_cnt - l0), 64'd1);

    // Test 4: out-of-range start
    do_ar(32'h4000);
    first_beat("t4_first_word0", 64'd0);
    wait_idle();
    chk("t4_err_oob", 64'(err_oob), 64'd1);
    repeat (5) tick();
    sample();
    chk("t4_err_oob_sticky", 64'(err_oob), 64'd1);
    tick();

    // Test 5: reset mid-burst
    do_ar(32'h0);
    cnt  = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      sample();
      if (rvalid && rready) cnt++;
      if (cnt == 2) done = 1'b1;
    end
    chk("t5_two_beats_timeout", 64'(done), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sample();
    chk("t5_rvalid_after_rst", 64'(rvalid), 64'd0);
    chk("t5_arready_after_rst", 64'(arready), 64'd1);
    chk("t5_err_oob_cleared", 64'(err_oob), 64'd0);
    tick();
    h0 = hs_cnt;
    do_ar(32'h0);
    wait_idle();
    chk("t5_beats", 64'(hs_cnt - h0), 64'd4);

    // Test 6: back-to-back ARs with arvalid held
    h0      = hs_cnt;
    l0      = last_cnt;
    araddr  = 32'h0;
    arvalid = 1'b1;
    done    = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      sample();
      if (arready) done = 1'b1;
    end
    chk("t6_ar0_timeout", 64'(done), 64'd1);
    tick();
    araddr = 32'h20;
    done   = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      sample();
      if (arready) done = 1'b1;
    end
    chk("t6_ar1_timeout", 64'(done), 64'd1);
    chk("t6_ar1_after_rlast", 64'(last_cnt - l0), 64'd1);
    chk("t6_ar1_after_4beats", 64'(hs_cnt - h0), 64'd4);
    tick();
    arvalid = 1'b0;
    wait_idle();
    chk("t6_beats", 64'(hs_cnt - h0), 64'd8);
    chk("t6_rlast_count", 64'(last_cnt - l0), 64'd2);

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", check_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
